branch_cmp_predictor: RTL and testbench

//  Parametrised branch-resolution unit for the ID stage: evaluates the branch condition on
//  two WIDTH-bit operands and trains a PC-indexed table of 2-bit saturating counters.
//  IF reads the table combinationally for a taken/not-taken prediction.

---
 rtl/branch_pkg.sv | 34 +++
 rtl/branch_pht.sv | 31 +++
 rtl/branch_cmp_predictor.sv | 101 ++++++++++
 tb/tb_branch_cmp_predictor.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolution / prediction block.
//  - br_op_e   : 4-bit condition codes (8..15 reserved, resolve as not-taken)
//  - SNT..ST   : 2-bit saturating counter states
//  - br_res_t  : registered result carried toward flush/redirect logic
//  - ctr_next  : saturating counter update
package branch_pkg;

  typedef enum logic [3:0] {
    BR_EQ  = 4'd0,
    BR_NE  = 4'd1,
    BR_LEZ = 4'd2,
    BR_GTZ = 4'd3,
    BR_LTZ = 4'd4,
    BR_GEZ = 4'd5,
    BR_LT  = 4'd6,
    BR_LTU = 4'd7
  } br_op_e;

  localparam logic [1:0] SNT = 2'd0;
  localparam logic [1:0] WNT = 2'd1;
  localparam logic [1:0] WT  = 2'd2;
  localparam logic [1:0] ST  = 2'd3;

  typedef struct packed {
    logic taken;
    logic mispredict;
  } br_res_t;

  function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic taken);
    if (taken) return (c == ST)  ? ST  : c + 2'd1;
    else       return (c == SNT) ? SNT : c - 2'd1;
  endfunction

endpackage

// File: rtl/branch_pht.sv
// Pattern history table: DEPTH x 2-bit saturating counters.
//  clk, reset   : clock, async active-low reset (all entries -> WNT)
//  rd_idx       : combinational read index
//  rd_taken     : MSB of the addressed counter
//  wr_en        : train the entry at wr_idx toward wr_taken on the next edge
// Reads see the pre-update value when read and write hit the same entry.
module branch_pht
  import branch_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_taken,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  logic [DEPTH-1:0][1:0] ctr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     ctr         <= {DEPTH{WNT}};
    else if (wr_en) ctr[wr_idx] <= ctr_next(ctr[wr_idx], wr_taken);
  end

  assign rd_taken = ctr[rd_idx][1];

endmodule

// File: rtl/branch_cmp_predictor.sv
// Branch resolution unit with a PC-indexed 2-bit counter predictor.
//  clk, reset          : clock, async active-low reset
//  pred_pc / pred_taken: IF-stage combinational prediction lookup
//  in_*                : resolve request (valid/ready), op, operands, pc, used prediction
//  flush               : drop held result, block acceptance this cycle
//  out_*               : registered outcome + mispredict flag (valid/ready)
//  mispred_cnt         : saturating count of mispredicts on valid ops
module branch_cmp_predictor
  import branch_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int PHT_DEPTH = 64,
  parameter int IDX_LSB   = 2,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pred_pc,
  output logic             pred_taken,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_pc,
  input  logic             in_pred,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_taken,
  output logic             out_mispredict,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int IDX_W = $clog2(PHT_DEPTH);

  logic    cond, op_ok, accept, a_neg, a_zero, mispred;
  br_res_t res_q;

  // Upper PC bits alias onto the table by design.
  logic unused_pc;
  assign unused_pc = ^{pred_pc, in_pc};

  assign a_neg  = in_a[WIDTH-1];
  assign a_zero = (in_a == '0);

  always_comb begin
    cond  = 1'b0;
    op_ok = 1'b1;
    case (in_op)
      BR_EQ:   cond = (in_a == in_b);
      BR_NE:   cond = (in_a != in_b);
      BR_LEZ:  cond = a_neg | a_zero;
      BR_GTZ:  cond = !a_neg && !a_zero;
      BR_LTZ:  cond = a_neg;
      BR_GEZ:  cond = !a_neg;
      BR_LT:   cond = ($signed(in_a) < $signed(in_b));
      BR_LTU:  cond = (in_a < in_b);
      default: op_ok = 1'b0;
    endcase
  end

  assign in_ready = !flush && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign mispred  = cond ^ in_pred;

  branch_pht #(.DEPTH(PHT_DEPTH), .IDX_W(IDX_W)) u_pht (
    .clk      (clk),
    .reset    (reset),
    .rd_idx   (pred_pc[IDX_LSB +: IDX_W]),
    .rd_taken (pred_taken),
    .wr_en    (accept && op_ok),
    .wr_idx   (in_pc[IDX_LSB +: IDX_W]),
    .wr_taken (cond)
  );

  // Accept has priority; it cannot coincide with flush since flush drops in_ready.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      res_q     <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      res_q     <= '{taken: cond, mispredict: mispred};
    end else if (flush || out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign out_taken      = res_q.taken;
  assign out_mispredict = res_q.mispredict;

  // Reserved ops still report a mispredict flag but are not counted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      mispred_cnt <= '0;
    else if (accept && op_ok && mispred && !(&mispred_cnt))
      mispred_cnt <= mispred_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_branch_cmp_predictor.sv
module tb_branch_cmp_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic        in_valid, in_ready;
  logic [3:0]  in_op;
  logic [31:0] in_a, in_b, in_pc;
  logic        in_pred, flush;
  logic        out_valid, out_ready, out_taken, out_mispredict;
  logic [15:0] mispred_cnt;

  branch_cmp_predictor dut (
    .clk(clk), .reset(reset), .pred_pc(pred_pc), .pred_taken(pred_taken),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .in_pc(in_pc), .in_pred(in_pred), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_taken(out_taken), .out_mispredict(out_mispredict),
    .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        taken;
    logic        misp;
    logic [15:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_cnt = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Bench model: mispredict = taken ^ used prediction, counted only for ops 0..7.
  task automatic push_exp(input logic [3:0] op, input logic pred, input logic taken);
    exp_t e;
    if (op < 4'd8 && (taken ^ pred) && exp_cnt != 16'hFFFF) exp_cnt++;
    e.taken = taken;
    e.misp  = taken ^ pred;
    e.cnt   = exp_cnt;
    exp_q.push_back(e);
  endtask

  task automatic set_req(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pc, input logic pred);
    in_op = op; in_a = a; in_b = b; in_pc = pc; in_pred = pred; in_valid = 1'b1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc, input logic pred, input logic taken);
    int n = 0;
    set_req(op, a, b, pc, pred);
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL issue_timeout: in_ready stuck 0 for op %0d", op);
    end
    push_exp(op, pred, taken);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d results never appeared", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic chk_pred(input string name, input logic [31:0] pc, input logic req);
    pred_pc = pc; #1;
    chk(name, {31'd0, pred_taken}, {31'd0, req});
  endtask

  // Monitor: compare on each handshake; a result held under flush is dropped.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset && out_valid && (out_ready || flush)) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output: taken=%0b misp=%0b", out_taken, out_mispredict);
        end else begin
          e = exp_q.pop_front();
          if (!flush) begin
            checks++;
            if ({out_taken, out_mispredict, mispred_cnt} !== {e.taken, e.misp, e.cnt}) begin
              errors++;
              $display("FAIL result: got taken=%0b misp=%0b cnt=%0d expected taken=%0b misp=%0b cnt=%0d",
                       out_taken, out_mispredict, mispred_cnt, e.taken, e.misp, e.cnt);
            end
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; in_pc = '0;
    in_pred = 1'b0; flush = 1'b0; out_ready = 1'b1; pred_pc = 32'h0040_0000;
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_taken", {31'd0, out_taken}, 32'd0);
    chk("rst_cnt", {16'd0, mispred_cnt}, 32'd0);
    chk("rst_pred", {31'd0, pred_taken}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // 1: first resolve, EQ 5==5 predicted not-taken -> mispredict; pc 0x40 counter 1->2
    chk_pred("t1_pred_0x400000", 32'h0040_0000, 1'b0);
    issue(4'd0, 32'd5, 32'd5, 32'h40, 1'b0, 1'b1);
    drain();
    chk("t1_cnt", {16'd0, mispred_cnt}, 32'd1);
    chk_pred("t1_pred_0x40", 32'h40, 1'b1);

    // 2: op sweep at pc 0x44
    issue(4'd0, 32'hFFFF_FFFF, 32'd1, 32'h44, 1'b0, 1'b0);
    issue(4'd1, 32'hFFFF_FFFF, 32'd1, 32'h44, 1'b0, 1'b1);
    issue(4'd2, 32'hFFFF_FFFF, 32'd1, 32'h44, 1'b0, 1'b1);
    issue(4'd3, 32'hFFFF_FFFF, 32'd1, 32'h44, 1'b0, 1'b0);
    issue(4'd4, 32'hFFFF_FFFF, 32'd1, 32'h44, 1'b0, 1'b1);
    issue(4'd5, 32'hFFFF_FFFF, 32'd1, 32'h44, 1'b0, 1'b0);
    issue(4'd6, 32'hFFFF_FFFF, 32'd1, 32'h44, 1'b0, 1'b1);
    issue(4'd7, 32'hFFFF_FFFF, 32'd1, 32'h44, 1'b0, 1'b0);
    issue(4'd2, 32'd0, 32'd1, 32'h44, 1'b0, 1'b1);
    issue(4'd5, 32'd0, 32'd1, 32'h44, 1'b0, 1'b1);
    issue(4'd3, 32'd0, 32'd1, 32'h44, 1'b0, 1'b0);
    issue(4'd4, 32'd0, 32'd1, 32'h44, 1'b0, 1'b0);
    drain();

    // 3: train pc 0x100 (index 0) up to 3 then back down to 1; 0x200 aliases it
    issue(4'd0, 32'd7, 32'd7, 32'h100, 1'b0, 1'b1);
    chk_pred("t3_after1", 32'h100, 1'b1);
    issue(4'd0, 32'd7, 32'd7, 32'h100, 1'b1, 1'b1);
    issue(4'd0, 32'd7, 32'd7, 32'h100, 1'b1, 1'b1);
    chk_pred("t3_sat", 32'h100, 1'b1);
    chk_pred("t3_alias_taken", 32'h200, 1'b1);
    issue(4'd1, 32'd7, 32'd7, 32'h100, 1'b1, 1'b0);
    chk_pred("t3_down1", 32'h100, 1'b1);
    issue(4'd1, 32'd7, 32'd7, 32'h200, 1'b1, 1'b0);
    chk_pred("t3_down2", 32'h100, 1'b0);
    chk_pred("t3_alias_nt", 32'h200, 1'b0);
    drain();

    // 4: backpressure for 3 cycles with a second request waiting
    out_ready = 1'b0;
    issue(4'd7, 32'd1, 32'd2, 32'h80, 1'b1, 1'b1);
    set_req(4'd6, 32'hFFFF_FFFF, 32'd0, 32'h80, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("t4_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("t4_hold_taken", {31'd0, out_taken}, 32'd1);
      chk("t4_hold_misp", {31'd0, out_mispredict}, 32'd0);
      chk("t4_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    push_exp(4'd6, 1'b0, 1'b1);
    #1;
    chk("t4_release_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();

    // 5: flush while holding a result with a request pending; pc 0xC0 counter 1->2
    out_ready = 1'b0;
    issue(4'd0, 32'd3, 32'd3, 32'hC0, 1'b0, 1'b1);
    set_req(4'd1, 32'd3, 32'd3, 32'hC0, 1'b1);
    flush = 1'b1;
    #1;
    chk("t5_flush_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    chk("t5_flush_valid", {31'd0, out_valid}, 32'd0);
    chk("t5_flush_cnt", {16'd0, mispred_cnt}, {16'd0, exp_cnt});
    chk_pred("t5_flush_pht", 32'hC0, 1'b1);
    exp_q.delete();
    flush = 1'b0;
    out_ready = 1'b1;
    push_exp(4'd1, 1'b1, 1'b0);
    #1;
    chk("t5_after_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk_pred("t5_after_pht", 32'hC0, 1'b0);
    drain();

    // 6: reserved op at pc 0x40 (counter 2) -> no training, no count
    issue(4'd9, 32'd5, 32'd5, 32'h40, 1'b1, 1'b0);
    drain();
    chk_pred("t6_pht_unchanged", 32'h40, 1'b1);
    chk("t6_cnt", {16'd0, mispred_cnt}, {16'd0, exp_cnt});

    // reset mid-stream with a held result
    out_ready = 1'b0;
    issue(4'd0, 32'd1, 32'd1, 32'h40, 1'b0, 1'b1);
    reset = 1'b0;
    #1;
    exp_q.delete();
    chk("t6_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("t6_rst_taken", {31'd0, out_taken}, 32'd0);
    chk("t6_rst_misp", {31'd0, out_mispredict}, 32'd0);
    chk("t6_rst_cnt", {16'd0, mispred_cnt}, 32'd0);
    chk_pred("t6_rst_pht", 32'h40, 1'b0);
    exp_cnt = '0;
    @(posedge clk); #1;
    reset = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    issue(4'd0, 32'd5, 32'd5, 32'h40, 1'b0, 1'b1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
